mdu_seq: RTL
============

Name: mdu_seq

Overview:
- Iterative RV64M multiply/divide unit.
- Sits directly downstream of the register file:
  - consumes its two read-data outputs as operands;
  - returns a result plus destination tag for the register file's write port.
- Multi-cycle start/busy/done handshake; one operation in flight.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 64, operand/result width; iteration count equals XLEN.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clock.
- start  input  1  request; accepted only in IDLE.
- op  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  XLEN  operand A (multiplicand/dividend), from register-file read port 1.
- rs2_data  input  XLEN  operand B (multiplier/divisor), from register-file read port 2.
- rd_in  input  5  destination register index.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result and rd_out valid in this cycle.
- result  output  XLEN  registered result.
- rd_out  output  5  destination tag captured at start.
- wb_en  output  1  done AND (rd_out != 0); drives register-file write enable.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state IDLE; operation aborted, no done pulse.
  - busy, done, wb_en = 0; result = 0; rd_out = 0; internal counter and accumulators cleared.
- States: IDLE, CALC, DONE.
  - IDLE: start=1 at an edge latches op, operands, rd_in, and operand signs. Next state is CALC, or DONE for special cases.
  - CALC: one iteration per edge. Counter runs 0..XLEN-1. The edge completing iteration XLEN-1 writes result and moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start while busy is ignored; no queuing.
  - start in the DONE cycle is ignored; earliest new acceptance is the following cycle.
- Latency, with cycle 0 = cycle in which start is sampled:
  - normal operations: done high in cycle XLEN+1 (65 for default);
  - special cases: done high in cycle 1.
- Operands are captured at start; later changes on rs1_data/rs2_data have no effect.
- Signed handling:
  - magnitudes are taken at start; the unsigned core iterates; the result is negated at the end if required;
  - signed/unsigned per op: MULH both signed, MULHSU A signed and B unsigned, MULHU/DIVU/REMU unsigned.
- Multiply:
  - 2*XLEN-bit product;
  - MUL returns bits [XLEN-1:0] (sign-independent); MULH/MULHSU/MULHU return bits [2*XLEN-1:XLEN] of the correctly signed product.
- Divide:
  - quotient truncates toward zero; remainder takes the dividend's sign.
- Special cases (fast path, no CALC):
  - divisor 0: DIV/DIVU result all ones; REM/REMU result = dividend.
  - signed overflow (A = -2^(XLEN-1), B = -1, DIV/REM): DIV result = -2^(XLEN-1); REM result 0.
- result holds its value after done until the next completion or reset.
- rd_out holds its value after done until the next accepted start or reset.

Decomposition:
- Shared package mdu_pkg:
  - funct3 op localparams (OP_MUL..OP_REMU);
  - state encoding (ST_IDLE, ST_CALC, ST_DONE);
  - XLEN default.
- Sub-module: mdu_negate, an XLEN-wide conditional two's-complement, instantiated for operand magnitudes and result sign correction.
- FSM and iteration datapath remain in mdu_seq.

Test Plan:
- MUL, A=7, B=8, rd=5, start one cycle → busy from cycle 1; done and wb_en only in cycle 65; result 56; rd_out 5.
- MULH, A=-1, B=-1 → 0. MULHU, same operands → 0xFFFF_FFFF_FFFF_FFFE. MULHSU, A=-1, B=2 → all ones.
- DIV, A=-7, B=2 → -3. REM, same operands → -1. DIVU, A=0x8000_0000_0000_0000, B=2 → 0x4000_0000_0000_0000.
- Division by zero:
  - DIV, A=12, B=0 → done in cycle 1, result all ones;
  - REMU, A=12, B=0 → result 12.
- Signed overflow: DIV, A=0x8000_0000_0000_0000, B=-1 → 0x8000_0000_0000_0000; REM, same operands → 0; both with done in cycle 1.
- Handshake and reset:
  - second start at cycle 10 → ignored, single done;
  - reset asserted at cycle 30 mid-CALC → next cycle busy=0, result=0, no done pulse;
  - rd=0 with MUL → done=1, wb_en=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
package mdu_pkg;

  localparam int unsigned XLEN_DEFAULT  = 64;
  localparam int unsigned CNT_W_DEFAULT = 7;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: y_c = en ? -a : a.
module mdu_negate #(
  parameter int unsigned W = 64
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output logic [W-1:0] y_c
);

  assign y_c = en ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, sign fixed up on the final edge.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);

  state_e           state;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  opnd;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic             res_neg;
  logic [CNT_W-1:0] cnt;

  logic             sign_a_c, sign_b_c, div_zero_c, div_ovf_c;
  logic [XLEN-1:0]  mag_a_c, mag_b_c, fast_res_c;
  logic [XLEN:0]    mul_sum_c, div_shift_c, div_trial_c;
  logic [XLEN-1:0]  nxt_hi_c, nxt_lo_c, raw_c, neg_res_c, final_res_c;

  // Operand sign/magnitude and fast-path decode for the request at the inputs
  always_comb begin
    sign_a_c   = ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM))
                 && rs1_data[XLEN-1];
    sign_b_c   = ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)) && rs2_data[XLEN-1];
    div_zero_c = op[2] && (rs2_data == '0);
    div_ovf_c  = ((op == OP_DIV) || (op == OP_REM))
                 && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    fast_res_c = '0;
    if (div_zero_c) begin
      fast_res_c = op[1] ? rs1_data : '1;
    end else if (div_ovf_c) begin
      fast_res_c = op[1] ? '0 : rs1_data;
    end
  end

  mdu_negate #(.W(XLEN)) u_neg_a (.en(sign_a_c), .a(rs1_data), .y_c(mag_a_c));
  mdu_negate #(.W(XLEN)) u_neg_b (.en(sign_b_c), .a(rs2_data), .y_c(mag_b_c));

  // One iteration: acc_hi is partial product / remainder, acc_lo is multiplier / quotient
  always_comb begin
    mul_sum_c   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift_c = {acc_hi, acc_lo[XLEN-1]};
    div_trial_c = div_shift_c - {1'b0, opnd};
    nxt_hi_c    = mul_sum_c[XLEN:1];
    nxt_lo_c    = {mul_sum_c[0], acc_lo[XLEN-1:1]};
    if (op_q[2]) begin
      nxt_hi_c = div_trial_c[XLEN] ? div_shift_c[XLEN-1:0] : div_trial_c[XLEN-1:0];
      nxt_lo_c = {acc_lo[XLEN-2:0], ~div_trial_c[XLEN]};
    end
  end

  always_comb begin
    raw_c = nxt_hi_c;
    if ((op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_DIVU)) begin
      raw_c = nxt_lo_c;
    end
  end

  mdu_negate #(.W(XLEN)) u_neg_r (.en(res_neg), .a(raw_c), .y_c(neg_res_c));

  // Negated high half borrows from the low half: only +1 when the low half is zero
  always_comb begin
    final_res_c = neg_res_c;
    if (((op_q == OP_MULH) || (op_q == OP_MULHSU)) && res_neg && (nxt_lo_c != '0)) begin
      final_res_c = ~nxt_hi_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_MUL;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      res_neg <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wb_en   <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            rd_out  <= rd_in;
            cnt     <= '0;
            busy    <= 1'b1;
            res_neg <= (op[2] && op[1]) ? sign_a_c : (sign_a_c ^ sign_b_c);
            opnd    <= op[2] ? mag_b_c : mag_a_c;
            acc_lo  <= op[2] ? mag_a_c : mag_b_c;
            acc_hi  <= '0;
            if (div_zero_c || div_ovf_c) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              wb_en  <= (rd_in != 5'd0);
              result <= fast_res_c;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_hi <= nxt_hi_c;
          acc_lo <= nxt_lo_c;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            wb_en  <= (rd_out != 5'd0);
            result <= final_res_c;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
